pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/squash controller for the 5-stage RISC-V pipeline. It drives the active-high-hold WEN and squash inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It detects load-use hazards, applies EX-stage redirects, freezes the pipe on multi-cycle data-memory waits, and drains and freezes the pipe on halt. State updates on negedge CLK, the same edge as the pipeline registers.

Parameters:
MAX_MEM_WAIT, 15, maximum consecutive MEM_WAIT cycles before timeout (range 1..255).
WBSEL_LOAD, 2'b01, WBSel encoding that marks a load writeback.

Ports:
CLK  in  1  clock; state changes on negedge.
RST  in  1  reset, asynchronous, active-low.
Rs1_id  in  5  ID source register 1.
Rs2_id  in  5  ID source register 2.
UseRs1_id  in  1  ID instruction reads rs1.
UseRs2_id  in  1  ID instruction reads rs2.
valid_id  in  1  ID stage holds a valid instruction.
Rdst_ex  in  5  EX destination register.
RWrEn_ex  in  1  EX register write enable, active-low (0 = writes).
WBSel_ex  in  2  EX writeback select.
valid_ex  in  1  EX stage valid.
halt_ex  in  1  EX instruction is a halt.
Redirect_ex  in  1  taken branch or jump resolved in EX.
MemReq_mem  in  1  MEM stage is issuing a data-memory access.
MemReady_mem  in  1  data memory completes the access this cycle.
valid_mem  in  1  MEM stage valid.
halt_wb  in  1  WB instruction is a halt.
valid_wb  in  1  WB stage valid.
WEN_pc, WEN_ifid, WEN_idex, WEN_exmem, WEN_memwb  out  1 each  1 = hold that register.
squash_ifid, squash_idex  out  1 each  insert a NOP bubble.
halted  out  1  pipeline frozen after halt or timeout.
mem_timeout  out  1  sticky flag: memory wait exceeded MAX_MEM_WAIT.
stall_cycles  out  32  saturating count of cycles with WEN_pc=1.

Behaviour:
- Reset (RST=0, asynchronous): state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0. While RST=0, all WEN=0, all squash=0 and halted=0, regardless of other inputs.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Internal terms:
  - load_use = valid_ex & valid_id & (WBSel_ex==WBSEL_LOAD) & !RWrEn_ex & (Rdst_ex!=0) & ((UseRs1_id & Rs1_id==Rdst_ex) | (UseRs2_id & Rs2_id==Rdst_ex)).
  - mem_busy = valid_mem & MemReq_mem & !MemReady_mem.
- Outputs are combinational from state and inputs, with this priority (highest first):
  1. HALTED: all WEN=1, squash=0, halted=1.
  2. mem_busy (any non-HALTED state): all WEN=1, squash=0. Redirect and load_use are ignored that cycle and re-evaluated after release.
  3. Redirect_ex: squash_ifid=1, squash_idex=1, all WEN=0. Redirect wins over load_use in the same cycle, because the ID instruction is wrong-path.
  4. load_use: WEN_pc=1, WEN_ifid=1, squash_idex=1, other WEN=0. This inserts one bubble, and the hazard self-clears the next cycle.
  5. DRAIN with none of the above: WEN_pc=1, squash_ifid=1, so NOPs follow the halt; other WEN=0.
  6. Otherwise: all 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_busy.
  - RUN -> DRAIN when valid_ex & halt_ex & !mem_busy & !Redirect_ex.
  - MEM_WAIT -> RUN, or to DRAIN if it was entered from DRAIN (remembered in a return bit), on !mem_busy.
  - MEM_WAIT -> HALTED when the wait counter reaches MAX_MEM_WAIT while mem_busy; mem_timeout is set to 1 at that point.
  - DRAIN -> HALTED when valid_wb & halt_wb.
  - HALTED exits only by reset.
- Wait counter (8-bit):
  - Loads 1 on entry to MEM_WAIT and increments each further mem_busy cycle.
  - Clears on exit.
  - A wait of exactly MAX_MEM_WAIT cycles with ready arriving in the cycle after the counter hits MAX_MEM_WAIT times out.
- stall_cycles: increments on each negedge with WEN_pc=1 in a non-HALTED state; saturates at 32'hFFFFFFFF with no wrap.
- Rdst_ex=0 never causes a load-use stall.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately, with counters cleared.

Test Plan:
1. Load-use: lw x5 in EX (WBSel_ex=01, RWrEn_ex=0, Rdst_ex=5), add using Rs1_id=5 -> exactly 1 cycle of WEN_pc=WEN_ifid=1 and squash_idex=1; stall_cycles=1. Repeat with Rdst_ex=0 -> no stall.
2. Redirect_ex=1 in the same cycle as load_use -> squash_ifid=squash_idex=1, all WEN=0, stall_cycles unchanged.
3. MemReq_mem=1, MemReady_mem low for 3 cycles, then high -> all WEN=1 for exactly 3 cycles, back to RUN, stall_cycles=3; a Redirect_ex asserted during the wait is held until release.
4. MemReady_mem held low with MAX_MEM_WAIT=4 -> HALTED after the 4th wait cycle; mem_timeout=1, halted=1, all WEN=1 persistently.
5. Halt: valid_ex & halt_ex -> DRAIN with WEN_pc=1 and squash_ifid=1 for 2 cycles; halt reaches WB -> halted=1.
6. RST pulsed low during MEM_WAIT (cycle 2) -> outputs 0 immediately, then RUN with mem_timeout=0 and stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/squash controller for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory wait freeze with timeout, and halt drain. State advances on negedge CLK.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_MEM_WAIT = 15,
  parameter logic [1:0]  WBSEL_LOAD   = 2'b01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  Rs1_id,
  input  logic [4:0]  Rs2_id,
  input  logic        UseRs1_id,
  input  logic        UseRs2_id,
  input  logic        valid_id,
  input  logic [4:0]  Rdst_ex,
  input  logic        RWrEn_ex,
  input  logic [1:0]  WBSel_ex,
  input  logic        valid_ex,
  input  logic        halt_ex,
  input  logic        Redirect_ex,
  input  logic        MemReq_mem,
  input  logic        MemReady_mem,
  input  logic        valid_mem,
  input  logic        halt_wb,
  input  logic        valid_wb,
  output logic        WEN_pc,
  output logic        WEN_ifid,
  output logic        WEN_idex,
  output logic        WEN_exmem,
  output logic        WEN_memwb,
  output logic        squash_ifid,
  output logic        squash_idex,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  // state    | meaning
  // RUN      | normal flow; hazards handled cycle by cycle
  // MEM_WAIT | data memory busy, whole pipe frozen, wait counter running
  // DRAIN    | halt passed EX; PC frozen and NOPs fed until halt reaches WB
  // HALTED   | pipe frozen until reset
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [8:0] MAX_WAIT = 9'(MAX_MEM_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ret_drain_q, ret_drain_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic       mem_busy;
  logic       load_use;
  logic       rs1_hit;
  logic       rs2_hit;
  logic [8:0] wait_inc;

  assign mem_busy = valid_mem & MemReq_mem & ~MemReady_mem;
  assign rs1_hit  = UseRs1_id & (Rs1_id == Rdst_ex);
  assign rs2_hit  = UseRs2_id & (Rs2_id == Rdst_ex);
  assign load_use = valid_ex & valid_id & (WBSel_ex == WBSEL_LOAD) & ~RWrEn_ex &
                    (Rdst_ex != 5'd0) & (rs1_hit | rs2_hit);
  assign wait_inc = {1'b0, wait_cnt_q} + 9'd1;

  // Outputs are forced low while reset is held, whatever the stage inputs say.
  always_comb begin
    WEN_pc      = 1'b0;
    WEN_ifid    = 1'b0;
    WEN_idex    = 1'b0;
    WEN_exmem   = 1'b0;
    WEN_memwb   = 1'b0;
    squash_ifid = 1'b0;
    squash_idex = 1'b0;
    halted      = 1'b0;
    if (RST) begin
      if (state_q == HALTED) begin
        WEN_pc    = 1'b1;
        WEN_ifid  = 1'b1;
        WEN_idex  = 1'b1;
        WEN_exmem = 1'b1;
        WEN_memwb = 1'b1;
        halted    = 1'b1;
      end else if (mem_busy) begin
        WEN_pc    = 1'b1;
        WEN_ifid  = 1'b1;
        WEN_idex  = 1'b1;
        WEN_exmem = 1'b1;
        WEN_memwb = 1'b1;
      end else if (Redirect_ex) begin
        // the ID instruction is wrong-path, so a coincident load-use is moot
        squash_ifid = 1'b1;
        squash_idex = 1'b1;
      end else if (load_use) begin
        WEN_pc      = 1'b1;
        WEN_ifid    = 1'b1;
        squash_idex = 1'b1;
      end else if (state_q == DRAIN) begin
        WEN_pc      = 1'b1;
        squash_ifid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    ret_drain_d   = ret_drain_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d     = MEM_WAIT;
          wait_cnt_d  = 8'd1;
          ret_drain_d = 1'b0;
        end else if (valid_ex && halt_ex && !Redirect_ex) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_busy) begin
          state_d     = MEM_WAIT;
          wait_cnt_d  = 8'd1;
          ret_drain_d = 1'b1;
        end else if (valid_wb && halt_wb) begin
          state_d = HALTED;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d     = ret_drain_q ? DRAIN : RUN;
          wait_cnt_d  = 8'd0;
          ret_drain_d = 1'b0;
        end else if (wait_inc >= MAX_WAIT) begin
          // this cycle is wait number MAX_MEM_WAIT; give up and freeze
          state_d       = HALTED;
          wait_cnt_d    = 8'd0;
          ret_drain_d   = 1'b0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc[7:0];
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    stall_cycles_d = stall_cycles_q;
    if (WEN_pc && (state_q != HALTED) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      ret_drain_q    <= 1'b0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      ret_drain_q    <= ret_drain_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
